// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
package seg_scan_pkg;

  // Default parameter values.
  localparam int unsigned DefaultSettleCycles = 16;
  localparam int unsigned DefaultFrameTimeout = 2000000;
  localparam int unsigned DefaultDarkCycles   = 100000;
  localparam int unsigned DefaultFlashWindow  = 50000000;

  // Active-low segment patterns, bit 0 = segment a; index = hex value.
  localparam logic [6:0] SegPattern [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [6:0] SegBlank = 7'h7F;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } scan_state_e;

  // One captured digit window.
  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       err;
    logic       dot;
  } digit_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low seven-segment pattern to a hex value.
module seg7_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] value,
  output logic       blank,
  output logic       err
);

  // Table lookup; anything unmatched flags err with value 0.
  always_comb begin
    value = 4'h0;
    blank = 1'b0;
    err   = 1'b1;
    if (seg_n == SegBlank) begin
      value = 4'hF;
      blank = 1'b1;
      err   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg_n == SegPattern[i]) begin
          value = 4'(i);
          err   = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 4-digit seven-segment display: samples the
// active-low pin bundle, rebuilds the four digits and publishes whole frames.
// Optional flash detection is enabled by defining SEG_SCAN_CAPTURE_FLASH_DETECT_EN.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DefaultSettleCycles,
  parameter int unsigned FRAME_TIMEOUT = DefaultFrameTimeout,
  parameter int unsigned DARK_CYCLES   = DefaultDarkCycles,
  parameter int unsigned FLASH_WINDOW  = DefaultFlashWindow
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  input  logic        dp_n,
  output logic [15:0] digits,
  output logic [3:0]  dots,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        stale,
  output logic        flashing
);

  localparam int unsigned MaxParam =
    max_u(max_u(SETTLE_CYCLES, FRAME_TIMEOUT), max_u(DARK_CYCLES, FLASH_WINDOW));
  localparam int unsigned CntW = $clog2(MaxParam) + 1;

  logic [11:0] sync1_q, sync2_q, prev_q;
  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic        dp_s, changed;
  logic        an_valid;
  logic [1:0]  an_idx;
  logic [CntW-1:0] stab_q, to_q;
  scan_state_e state_q, state_d;
  logic        sample, commit;
  logic [3:0]  seen_q;
  digit_t [3:0] shadow_q;
  digit_t      dec;
  logic [15:0] digits_q;
  logic [3:0]  dots_q, blank_q, err_q;
  logic        frame_valid_q, stale_q;

  // Two-flop synchronizer plus one-sample history for change detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {an_n, seg_n, dp_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign an_s    = sync2_q[11:8];
  assign seg_s   = sync2_q[7:1];
  assign dp_s    = sync2_q[0];
  assign changed = (sync2_q != prev_q);

  // Exactly one anode low selects a digit; idle and multi-anode glitches do not.
  always_comb begin
    an_valid = 1'b1;
    an_idx   = 2'd0;
    unique case (an_s)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  seg7_pattern_decode u_decode (
    .seg_n (seg_s),
    .value (dec.value),
    .blank (dec.blank),
    .err   (dec.err)
  );
  assign dec.dot = ~dp_s;

  // Stability counter: run length of identical samples, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stab_q <= '0;
    end else if (changed) begin
      stab_q <= '0;
    end else if (stab_q != CntW'(SETTLE_CYCLES)) begin
      stab_q <= stab_q + 1'b1;
    end
  end

  // Window FSM next state; samples once per settled window.
  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (an_valid) state_d = StSettle;
      end
      StSettle: begin
        if (changed) begin
          state_d = an_valid ? StSettle : StIdle;
        end else if (stab_q >= CntW'(SETTLE_CYCLES - 1)) begin
          sample  = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (changed) state_d = an_valid ? StSettle : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign commit = (seen_q == 4'b1111);

  // FSM state, shadow digits and seen mask; a commit clears the mask before
  // any same-cycle sample lands so that sample belongs to the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      seen_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= (commit ? 4'b0000 : seen_q) | (sample ? (4'b0001 << an_idx) : 4'b0000);
      if (sample) shadow_q[an_idx] <= dec;
    end
  end

  // Published frame outputs and the one-cycle commit strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_q      <= '0;
      dots_q        <= '0;
      blank_q       <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= commit;
      if (commit) begin
        for (int i = 0; i < 4; i++) begin
          digits_q[4*i +: 4] <= shadow_q[i].value;
          dots_q[i]          <= shadow_q[i].dot;
          blank_q[i]         <= shadow_q[i].blank;
          err_q[i]           <= shadow_q[i].err;
        end
      end
    end
  end

  // Frame timeout: saturating counter, stale sticks until the next commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q    <= '0;
      stale_q <= 1'b1;
    end else if (commit) begin
      to_q    <= '0;
      stale_q <= 1'b0;
    end else if (to_q == CntW'(FRAME_TIMEOUT)) begin
      stale_q <= 1'b1;
    end else begin
      to_q <= to_q + 1'b1;
    end
  end

  assign digits      = digits_q;
  assign dots        = dots_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = frame_valid_q;
  assign stale       = stale_q;

`ifdef SEG_SCAN_CAPTURE_FLASH_DETECT_EN
  logic [CntW-1:0] dark_q, since_q;
  logic            armed_q, flashing_q;
  logic            an_idle, dark_start;

  assign an_idle    = (an_s == 4'hF);
  // The DARK_CYCLES-th consecutive idle sample marks the start of a dark interval.
  assign dark_start = an_idle && (dark_q == CntW'(DARK_CYCLES - 1));

  // Dark run length and spacing between dark interval starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dark_q     <= '0;
      since_q    <= '0;
      armed_q    <= 1'b0;
      flashing_q <= 1'b0;
    end else begin
      if (!an_idle) begin
        dark_q <= '0;
      end else if (dark_q != CntW'(DARK_CYCLES)) begin
        dark_q <= dark_q + 1'b1;
      end
      if (dark_start) begin
        if (armed_q && (since_q < CntW'(FLASH_WINDOW))) flashing_q <= 1'b1;
        armed_q <= 1'b1;
        since_q <= '0;
      end else if (armed_q) begin
        if (since_q == CntW'(FLASH_WINDOW)) begin
          armed_q    <= 1'b0;
          flashing_q <= 1'b0;
        end else begin
          since_q <= since_q + 1'b1;
        end
      end
    end
  end

  assign flashing = flashing_q;
`else
  assign flashing = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with a frame scoreboard.
module tb_seg_scan_capture;

  localparam int unsigned Settle  = 16;
  localparam int unsigned Timeout = 1500;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  logic        clk, reset_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        dp_n;
  logic [15:0] digits;
  logic [3:0]  dots, blank, err;
  logic        frame_valid, stale, flashing;

  int n_cmp = 0;
  int n_err = 0;
  int nframes = 0;
  int cyc = 0;
  int last_fv_cyc = 0;
  int waited;
  frame_t exp_q[$];
  frame_t got, want;
  logic [6:0] pat [16];
  logic [6:0] pat_hi [16];

  seg_scan_capture #(
    .SETTLE_CYCLES (Settle),
    .FRAME_TIMEOUT (Timeout)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .dp_n        (dp_n),
    .digits      (digits),
    .dots        (dots),
    .blank       (blank),
    .err         (err),
    .frame_valid (frame_valid),
    .stale       (stale),
    .flashing    (flashing)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every frame_valid pulse pops and compares one expected frame.
  always @(negedge clk) begin
    if (reset_n && frame_valid) begin
      nframes++;
      last_fv_cyc = cyc;
      check("frame expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got  = '{digits: digits, dots: dots, blank: blank, err: err};
        check("sb digits", got.digits, want.digits);
        check("sb dots", 16'(got.dots), 16'(want.dots));
        check("sb blank", 16'(got.blank), 16'(want.blank));
        check("sb err", 16'(got.err), 16'(want.err));
      end
    end
  end

  task automatic win(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    an_n  = an;
    seg_n = seg;
    dp_n  = dp;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    win(4'hF, 7'h7F, 1'b1, n);
  endtask

  // Four 40-cycle windows, leftmost digit first; dp_on bit i lights digit i.
  task automatic frame(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                       input logic [6:0] p0, input logic [3:0] dp_on);
    win(4'b0111, p3, ~dp_on[3], 40);
    win(4'b1011, p2, ~dp_on[2], 40);
    win(4'b1101, p1, ~dp_on[1], 40);
    win(4'b1110, p0, ~dp_on[0], 40);
    idle(30);
  endtask

  initial begin
    pat_hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 16; i++) pat[i] = ~pat_hi[i];

    reset_n = 1'b0;
    an_n = 4'hF;
    seg_n = 7'h7F;
    dp_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst digits", digits, 16'h0000);
    check("rst dots", 16'(dots), 16'h0);
    check("rst blank", 16'(blank), 16'h0);
    check("rst err", 16'(err), 16'h0);
    check("rst frame_valid", 16'(frame_valid), 16'h0);
    check("rst stale", 16'(stale), 16'h1);
    check("rst flashing", 16'(flashing), 16'h0);
    reset_n = 1'b1;
    idle(5);

    // Basic frame with dp on digit 2.
    exp_q.push_back('{digits: 16'h1234, dots: 4'b0100, blank: 4'b0000, err: 4'b0000});
    frame(pat[1], pat[2], pat[3], pat[4], 4'b0100);
    check("f1 count", 16'(nframes), 16'd1);
    check("f1 stale", 16'(stale), 16'd0);
    check("f1 digits", digits, 16'h1234);

    // Blank leftmost digit, invalid rightmost digit, dp on digit 1.
    exp_q.push_back('{digits: 16'hF9A0, dots: 4'b0010, blank: 4'b1000, err: 4'b0001});
    frame(7'h7F, pat[9], pat[10], 7'b0110110, 4'b0010);
    check("f2 count", 16'(nframes), 16'd2);
    check("f2 blank", 16'(blank), 16'h8);
    check("f2 err", 16'(err), 16'h1);

    // Digit 3 resampled (latest wins) and a multi-anode glitch window ignored.
    exp_q.push_back('{digits: 16'hCDEF, dots: 4'b0000, blank: 4'b0000, err: 4'b0000});
    win(4'b0111, pat[5], 1'b1, 40);
    win(4'b0111, pat[12], 1'b1, 40);
    win(4'b0011, pat[8], 1'b0, 40);
    win(4'b1011, pat[13], 1'b1, 40);
    win(4'b1101, pat[14], 1'b1, 40);
    win(4'b1110, pat[15], 1'b1, 40);
    idle(30);
    check("f3 count", 16'(nframes), 16'd3);
    check("f3 digits", digits, 16'hCDEF);

    // Windows shorter than the settle time never sample.
    win(4'b0111, pat[0], 1'b1, 10);
    win(4'b1011, pat[1], 1'b1, 10);
    win(4'b1101, pat[2], 1'b1, 10);
    win(4'b1110, pat[3], 1'b1, 10);
    idle(30);
    check("short count", 16'(nframes), 16'd3);
    check("short stale early", 16'(stale), 16'd0);
    waited = 0;
    while (!stale && waited < 2 * Timeout) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("stale rises", 16'(stale), 16'd1);
    check("stale delay in range",
          16'(((cyc - last_fv_cyc) >= int'(Timeout) - 2) && ((cyc - last_fv_cyc) <= int'(Timeout) + 4)),
          16'd1);
    check("stale holds digits", digits, 16'hCDEF);
    check("stale count", 16'(nframes), 16'd3);

    // Reset mid-frame: two windows captured, then discarded by reset.
    win(4'b1101, pat[1], 1'b1, 40);
    win(4'b1110, pat[2], 1'b1, 40);
    idle(5);
    reset_n = 1'b0;
    #1;
    check("midrst digits", digits, 16'h0000);
    check("midrst stale", 16'(stale), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(5);
    exp_q.push_back('{digits: 16'h5678, dots: 4'b0000, blank: 4'b0000, err: 4'b0000});
    win(4'b0111, pat[5], 1'b1, 40);
    win(4'b1011, pat[6], 1'b1, 40);
    win(4'b1101, pat[7], 1'b1, 40);
    check("pre-commit count", 16'(nframes), 16'd3);
    check("pre-commit stale", 16'(stale), 16'd1);
    win(4'b1110, pat[8], 1'b1, 40);
    idle(30);
    check("post-rst count", 16'(nframes), 16'd4);
    check("post-rst digits", digits, 16'h5678);
    check("post-rst stale", 16'(stale), 16'd0);
    check("scoreboard drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
